// File: rtl/str_rep_seq.sv
// -----------------------------------------------------------------------------
// str_rep_seq
//   Sequencer for REP MOVSD / REP STOSD. For each iteration it handshakes one
//   dword read (MOVS only) and one dword write with the memory stage. It then
//   steps EDI (and ESI for MOVS) through alu2 with the string opcode, and
//   counts ECX down when the REP prefix is present. busy stalls the front end
//   until the instruction retires with a one-cycle done pulse.
//
//   Optional feature macro: STR_REP_INTR_EN
//     defined   : a pending interrupt at the loop decision retires the REP
//                 early with eip_hold = 1, so the instruction restarts later.
//     undefined : irq_pend is ignored and eip_hold is always 0.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start           launch pulse, sampled only while idle
//   is_movs         1 = MOVSD (read then write), 0 = STOSD (write only)
//   rep_en          REP prefix present
//   ecx_in          ECX value at launch
//   irq_pend        pending interrupt (only with STR_REP_INTR_EN)
//   mem_ack         memory stage completed the current request
//   mem_req/mem_we  memory request valid / 1 = write ES:EDI, 0 = read DS:ESI
//   mem_rd_size     constant dword size code
//   mem_wr_size     constant dword size code
//   alu2_op         alu2 opcode (string step or idle pass-through)
//   ptr_sel/ptr_we  pointer select (0 = EDI, 1 = ESI) and its write enable
//   ecx_out/ecx_we  decremented ECX value and its write enable
//   busy            front-end stall
//   done/eip_hold   retire pulse; eip_hold = retire without advancing EIP
//
//   All outputs except the size constants are registered. They are decoded
//   from the next state, so each one is valid in the cycle its state is
//   occupied.
// -----------------------------------------------------------------------------
module str_rep_seq #(
  parameter int unsigned CNT_W        = 32,
  parameter logic [3:0]  ALU2_OP_STR  = 4'b0101,
  parameter logic [3:0]  ALU2_OP_IDLE = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_movs,
  input  logic             rep_en,
  input  logic [CNT_W-1:0] ecx_in,
  input  logic             irq_pend,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_rd_size,
  output logic [1:0]       mem_wr_size,
  output logic [3:0]       alu2_op,
  output logic             ptr_sel,
  output logic             ptr_we,
  output logic [CNT_W-1:0] ecx_out,
  output logic             ecx_we,
  output logic             busy,
  output logic             done,
  output logic             eip_hold
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_UPD_DI = 3'd3,
    S_UPD_SI = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             movs_q, movs_d;
  logic             rep_q, rep_d;

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       alu2_op_q, alu2_op_d;
  logic             ptr_sel_q, ptr_sel_d;
  logic             ptr_we_q, ptr_we_d;
  logic [CNT_W-1:0] ecx_out_q, ecx_out_d;
  logic             ecx_we_q, ecx_we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eip_hold_q, eip_hold_d;

  logic [CNT_W-1:0] dec_cnt_s;   // count after this cycle's decrement
  logic             loop_last_s; // last iteration completed
  logic             loop_irq_s;  // early exit requested by an interrupt
  state_t           loop_tgt_s;  // loop decision target

  // Loop decision: evaluated on the decremented count.
  always_comb begin
    if ((state_q == S_UPD_DI) && rep_q) begin
      dec_cnt_s = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      dec_cnt_s = cnt_q;
    end
    loop_last_s = !rep_q || (dec_cnt_s == {CNT_W{1'b0}});
`ifdef STR_REP_INTR_EN
    loop_irq_s  = rep_q && (dec_cnt_s != {CNT_W{1'b0}}) && irq_pend;
`else
    loop_irq_s  = 1'b0;
`endif
    if (loop_last_s || loop_irq_s) begin
      loop_tgt_s = S_FIN;
    end else if (movs_q) begin
      loop_tgt_s = S_RD;
    end else begin
      loop_tgt_s = S_WR;
    end
  end

`ifndef STR_REP_INTR_EN
  logic unused_irq_s;
  assign unused_irq_s = irq_pend;
`endif

  // Next-state logic and latching of the instruction attributes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    movs_d     = movs_q;
    rep_d      = rep_q;
    eip_hold_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          movs_d = is_movs;
          rep_d  = rep_en;
          cnt_d  = ecx_in;
          if (rep_en && (ecx_in == {CNT_W{1'b0}})) begin
            state_d = S_FIN;
          end else if (is_movs) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_UPD_DI;
        end else begin
          state_d = S_WR;
        end
      end
      S_UPD_DI: begin
        cnt_d = dec_cnt_s;
        if (movs_q) begin
          state_d = S_UPD_SI;
        end else begin
          state_d    = loop_tgt_s;
          eip_hold_d = loop_irq_s;
        end
      end
      S_UPD_SI: begin
        state_d    = loop_tgt_s;
        eip_hold_d = loop_irq_s;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the state being entered, so registered outputs line up with it.
  always_comb begin
    mem_req_d = (state_d == S_RD) || (state_d == S_WR);
    mem_we_d  = (state_d == S_WR);
    ptr_we_d  = (state_d == S_UPD_DI) || (state_d == S_UPD_SI);
    ptr_sel_d = (state_d == S_UPD_SI);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d    = (state_d == S_FIN);
    if (ptr_we_d) begin
      alu2_op_d = ALU2_OP_STR;
    end else begin
      alu2_op_d = ALU2_OP_IDLE;
    end
    if ((state_d == S_UPD_DI) && rep_d) begin
      ecx_we_d  = 1'b1;
      ecx_out_d = cnt_d - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ecx_we_d  = 1'b0;
      ecx_out_d = ecx_out_q;
    end
  end

  // State, attribute and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      movs_q     <= 1'b0;
      rep_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      alu2_op_q  <= ALU2_OP_IDLE;
      ptr_sel_q  <= 1'b0;
      ptr_we_q   <= 1'b0;
      ecx_out_q  <= {CNT_W{1'b0}};
      ecx_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eip_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      movs_q     <= movs_d;
      rep_q      <= rep_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      alu2_op_q  <= alu2_op_d;
      ptr_sel_q  <= ptr_sel_d;
      ptr_we_q   <= ptr_we_d;
      ecx_out_q  <= ecx_out_d;
      ecx_we_q   <= ecx_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      eip_hold_q <= eip_hold_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_rd_size = 2'b10;
  assign mem_wr_size = 2'b10;
  assign alu2_op     = alu2_op_q;
  assign ptr_sel     = ptr_sel_q;
  assign ptr_we      = ptr_we_q;
  assign ecx_out     = ecx_out_q;
  assign ecx_we      = ecx_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign eip_hold    = eip_hold_q;

endmodule
